// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: issues MULT/DIV, holds the result as pending, commits HI/LO on countdown expiry.
// Latency 5 cycles (mul) / 10 cycles (div); no backpressure input, MDStall holds the ID-stage MDU instruction instead.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        IDisMD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut,
    output logic        Busy,
    output logic        Done,
    output logic        MDStall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        issue, commit;
    logic        mt_hi, mt_lo;
    logic [31:0] pending_hi, pending_lo;
    logic [31:0] res_hi, res_lo;

    logic        is_signed, a_neg, b_neg;
    logic [63:0] prod;
    logic [31:0] num, den, den_safe, quo, rem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        issue   = 1'b0;
        commit  = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU: begin
                            state_d = MUL;
                            cnt_d   = 4'd5;
                            issue   = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = 4'd10;
                            issue   = 1'b1;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                // starts arriving here are ignored, including on the commit edge
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state == MUL) || (state == DIV);
        MDStall = IDisMD && (Busy || (start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU)));
        case (MDOp)
            OP_MFHI: MDOut = HI;
            OP_MFLO: MDOut = LO;
            default: MDOut = 32'd0;
        endcase
    end

    always_comb begin
        is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_neg     = is_signed && A[31];
        b_neg     = is_signed && B[31];
        // low 64 bits of a 64x64 product of extended operands are exact for both signednesses
        prod      = {{32{a_neg}}, A} * {{32{b_neg}}, B};
        num       = a_neg ? (~A + 32'd1) : A;
        den       = b_neg ? (~B + 32'd1) : B;
        den_safe  = (den == 32'd0) ? 32'd1 : den;
        quo       = num / den_safe;
        rem       = num % den_safe;
        if (MDOp == OP_MULT || MDOp == OP_MULTU) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (B == 32'd0) begin
            res_hi = HI;
            res_lo = LO;
        end else begin
            res_lo = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
            res_hi = a_neg ? (~rem + 32'd1) : rem;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            HI         <= 32'd0;
            LO         <= 32'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            Done       <= 1'b0;
        end else begin
            Done <= commit;
            if (issue) begin
                pending_hi <= res_hi;
                pending_lo <= res_lo;
            end
            if (commit) begin
                HI <= pending_hi;
                LO <= pending_lo;
            end else begin
                if (mt_hi) HI <= A;
                if (mt_lo) LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDOp;
    logic [31:0] A, B;
    logic        IDisMD;
    logic [31:0] HI, LO, MDOut;
    logic        Busy, Done, MDStall;

    int checks = 0;
    int errors = 0;
    int done_seen;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
        .IDisMD(IDisMD), .HI(HI), .LO(LO), .MDOut(MDOut), .Busy(Busy),
        .Done(Done), .MDStall(MDStall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // drive one start for a single edge, then return to idle inputs
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDOp = op; A = a; B = b;
        cyc();
        start = 1'b0; MDOp = 4'd0;
        #1;
    endtask

    // check the busy window then the commit cycle
    task automatic run_busy(input string tag, input int n, input logic [31:0] eh, input logic [31:0] el);
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            chk({tag, "_nodone"}, 32'(Done), 32'd0);
            cyc();
        end
        chk({tag, "_idle"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_hi"}, HI, eh);
        chk({tag, "_lo"}, LO, el);
        cyc();
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; MDOp = 4'd1; A = 32'd9; B = 32'd9; IDisMD = 1'b1;
        cyc(); cyc();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall_issue", 32'(MDStall), 32'd1);
        start = 1'b0; MDOp = 4'd0; IDisMD = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(MDStall), 32'd0);
        reset = 1'b1;
        cyc();

        // MULT -2 * 3
        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi_held", HI, 32'd0);
        run_busy("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);

        // MULTU with a stray MTHI start during busy (must be ignored)
        issue(4'd2, 32'hFFFFFFFE, 32'd3);
        start = 1'b1; MDOp = 4'd7; A = 32'hDEADBEEF;
        chk("multu_b1", 32'(Busy), 32'd1);
        cyc();
        start = 1'b0; MDOp = 4'd0;
        #1;
        run_busy("multu", 4, 32'h00000002, 32'hFFFFFFFA);

        // DIV -7 / 2 with the ID instruction held on an MDU op
        IDisMD = 1'b1;
        start = 1'b1; MDOp = 4'd3; A = 32'hFFFFFFF9; B = 32'd2;
        #1;
        chk("div_stall_issue", 32'(MDStall), 32'd1);
        cyc();
        start = 1'b0; MDOp = 4'd0;
        #1;
        for (int i = 1; i <= 10; i++) begin
            chk("div_stall_busy", 32'(MDStall), 32'd1);
            chk("div_busy", 32'(Busy), 32'd1);
            cyc();
        end
        chk("div_stall_end", 32'(MDStall), 32'd0);
        chk("div_done", 32'(Done), 32'd1);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        start = 1'b1; MDOp = 4'd6;
        #1;
        chk("mflo_stall", 32'(MDStall), 32'd0);
        chk("mflo_out", MDOut, 32'hFFFFFFFD);
        cyc();
        start = 1'b0; MDOp = 4'd0; IDisMD = 1'b0;
        chk("mflo_nobusy", 32'(Busy), 32'd0);

        // DIVU by zero leaves HI/LO alone
        issue(4'd4, 32'd7, 32'd0);
        run_busy("divu0", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // signed overflow
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        run_busy("divovf", 10, 32'd0, 32'h80000000);

        // DIV positive dividend, negative divisor: 7 / -2 = -3 r 1
        issue(4'd3, 32'd7, 32'hFFFFFFFE);
        run_busy("divneg", 10, 32'd1, 32'hFFFFFFFD);

        // MTHI / MTLO / MFHI
        issue(4'd7, 32'h12345678, 32'd0);
        chk("mthi_busy", 32'(Busy), 32'd0);
        chk("mthi_hi", HI, 32'h12345678);
        start = 1'b1; MDOp = 4'd5;
        #1;
        chk("mfhi_out", MDOut, 32'h12345678);
        chk("mfhi_busy", 32'(Busy), 32'd0);
        cyc();
        chk("mfhi_nodone", 32'(Done), 32'd0);
        start = 1'b0; MDOp = 4'd0;
        issue(4'd8, 32'hCAFEF00D, 32'd0);
        chk("mtlo_lo", LO, 32'hCAFEF00D);
        chk("mtlo_hi_kept", HI, 32'h12345678);
        chk("none_out", MDOut, 32'd0);

        // undefined opcode is a no-op
        issue(4'd15, 32'h11111111, 32'd1);
        chk("undef_busy", 32'(Busy), 32'd0);
        chk("undef_lo", LO, 32'hCAFEF00D);

        // reset on the third busy cycle of a MULT
        issue(4'd1, 32'd5, 32'd6);
        chk("rmul_b1", 32'(Busy), 32'd1);
        cyc();
        chk("rmul_b2", 32'(Busy), 32'd1);
        cyc();
        chk("rmul_b3", 32'(Busy), 32'd1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("rmul_busy", 32'(Busy), 32'd0);
        chk("rmul_hi", HI, 32'd0);
        chk("rmul_lo", LO, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (Done) done_seen++;
            cyc();
        end
        chk("rmul_no_done", 32'(done_seen), 32'd0);
        chk("rmul_lo_final", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
